// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - Bomberman game sequencer: IDLE/READY/PLAY/HIT/OVER with lives tracking
// Optional post-hit invulnerability window enabled by `define GAME_STATE_CTRL_INVULN_EN
module game_state_ctrl #(
    parameter int LIVES         = 3,
    parameter int READY_CYCLES  = 25_000_000,
    parameter int INVULN_CYCLES = 50_000_000,
    parameter int CNT_W         = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       death_signal,
    output logic       enemy_start,
    output logic       respawn,
    output logic [2:0] lives,
    output logic       game_over,
    output logic       invuln,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_READY = 3'b001,
        ST_PLAY  = 3'b010,
        ST_HIT   = 3'b011,
        ST_OVER  = 3'b100
    } state_t;

    localparam logic [2:0]       LIVES_INIT  = 3'(LIVES);
    localparam logic [CNT_W-1:0] READY_LAST  = CNT_W'(READY_CYCLES - 1);
    localparam logic [CNT_W-1:0] INVULN_LAST = CNT_W'(INVULN_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       lives_q;
    logic [2:0]       lives_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_done;
    logic             s1, s2, s3;
    logic             death_q;
    logic             start_pulse;
    logic             respawn_q;

    assign start_pulse = s2 & ~s3;

    // Only READY and HIT are timed phases; pick the terminal value for the current one.
    assign cnt_done = (cnt_q == ((state_q == ST_HIT) ? INVULN_LAST : READY_LAST));

    // Button synchronizer with edge-detect flop, and one-stage registering of the collision level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            death_q <= 1'b0;
        end else begin
            s1      <= start_btn;
            s2      <= s1;
            s3      <= s2;
            death_q <= death_signal;
        end
    end

    // Next-state and lives update; a hit is only taken while in PLAY.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        case (state_q)
            ST_IDLE: begin
                lives_d = LIVES_INIT;
                if (start_pulse) state_d = ST_READY;
            end
            ST_READY: begin
                if (cnt_done) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (death_q) begin
                    if (lives_q == 3'd1) begin
                        lives_d = 3'd0;
                        state_d = ST_OVER;
                    end else begin
                        lives_d = lives_q - 3'd1;
`ifdef GAME_STATE_CTRL_INVULN_EN
                        state_d = ST_HIT;
`else
                        state_d = ST_READY;
`endif
                    end
                end
            end
            ST_HIT: begin
                if (cnt_done) state_d = ST_PLAY;
            end
            ST_OVER: begin
                if (start_pulse) begin
                    lives_d = LIVES_INIT;
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, lives and the respawn pulse that marks the first cycle of each READY entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            lives_q   <= LIVES_INIT;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            respawn_q <= (state_d == ST_READY) && (state_q != ST_READY);
        end
    end

    // Phase counter: restarts on every transition, runs only in the timed phases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (state_q == ST_READY || state_q == ST_HIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign lives       = lives_q;
    assign respawn     = respawn_q;
    assign enemy_start = (state_q == ST_PLAY) || (state_q == ST_HIT);
    assign game_over   = (state_q == ST_OVER);
`ifdef GAME_STATE_CTRL_INVULN_EN
    assign invuln      = (state_q == ST_HIT);
`else
    assign invuln      = 1'b0;
`endif

endmodule
